div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Multi-cycle radix-2 restoring divider.
- Responder side of the ALU divide handshake: the ALU raises start_i with operands, holds it until ready_o, then drops it.
- Produces {remainder, quotient} for the HI/LO path; serves DIV (signed) and DIVU (unsigned).
- Sits beside the multiplier in the execute stage; the ALU stalls the pipeline while a divide is computing.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W. Only 32 is required to work; the counter width derives from it.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- opdata1_i  in  DATA_W  dividend (rs)
- opdata2_i  in  DATA_W  divisor (rt)
- start_i  in  1  request; level, held by the initiator until ready_o seen
- annul_i  in  1  abort current or pending divide (flush/exception)
- result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}, i.e. {HI, LO}
- ready_o  out  1  result valid

Behaviour:
- Reset, asynchronous, any state: state=IDLE, ready_o=0, result_o=0, counter=0, internal regs=0.
- States and encodings: IDLE, BYZERO, ON, END.
- IDLE:
  - start_i=1 and annul_i=0 with divisor==0 -> BYZERO.
  - start_i=1 and annul_i=0 with divisor!=0 -> ON.
  - On leaving IDLE, latch signed_div_i and operand magnitudes: two's-complement negate when signed and MSB=1.
  - Latch the quotient sign (dividend MSB XOR divisor MSB) and the remainder sign (dividend MSB); both are 0 when unsigned.
  - annul_i has priority over start_i.
- BYZERO: next edge -> END with result_o=0, ready_o=1.
- ON:
  - One quotient bit per edge, 32 iterations (counter 0..31).
  - Per edge: partial remainder shifted left with the next dividend bit; trial-subtract the divisor; keep the difference if non-negative and set the quotient bit.
  - On the 32nd ON edge: apply sign fix-up, register result_o, set ready_o=1, go to END.
  - Operand and signed_div_i changes during ON are ignored.
  - annul_i=1 in ON -> IDLE next edge; ready_o stays 0 and result_o stays 0.
- END:
  - ready_o=1 and result_o held while start_i=1.
  - start_i=0 -> IDLE next edge; ready_o=0 and result_o=0 on that edge.
  - annul_i=1 in END -> IDLE as well.
- Latency:
  - The edge sampling start is E0; ready_o is high after E32 (divisor!=0) or after E1 (divisor==0).
  - With the ALU dropping start_i combinationally on ready_o, ready_o is high exactly one cycle.
- Sign rules:
  - Quotient is negative iff the signs differ.
  - Remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF signed -> quotient 0x80000000, remainder 0, no flag.
- start_i re-asserted while in ON or BYZERO: no effect. No new request is accepted until IDLE.
- No divide-by-zero exception output; the result is 0 by definition.

Decomposition:
- Shared header define_div.vh holds:
  - state encodings `DIV_IDLE, `DIV_BYZERO, `DIV_ON, `DIV_END (2-bit);
  - `DIV_ITER = 32;
  - the result-field bit-range macros for HI/LO.
- Single module; no sub-module needed. The trial subtract is a 33-bit inline expression.

Test Plan:
- Unsigned: 100 / 7, start held until ready -> ready_o high after E32 for one cycle; result_o = {32'd2, 32'd14}; IDLE next cycle with result_o=0.
- Signed: -7 / 2 -> result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}. Also 7 / -2 -> {32'd1, 32'hFFFFFFFD}.
- Divide by zero: 0x1234 / 0, signed and unsigned -> ready_o after E1, result_o = 0. Also 0xFFFFFFFF / 1 unsigned -> {0, 32'hFFFFFFFF} at E32.
- Overflow corner: 0x80000000 / 0xFFFFFFFF signed -> {0, 32'h80000000}. Same operands unsigned -> {32'h80000000, 0}.
- Annul at E10 of ON -> IDLE at E11, ready_o never rises. A new start at E12 (50/5) -> {0, 32'd10} after E44.
- Async rst pulsed mid-ON between edges -> ready_o=0, result_o=0 immediately. Operands toggled during ON (no reset) do not change the result.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
// The state encodings are visible here so other execute-stage blocks can decode them.
package div_seq_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_ITER   = 32;

    // Result field boundaries for the {HI, LO} pair
    localparam int DIV_LO_LSB = 0;
    localparam int DIV_LO_MSB = DIV_DATA_W - 1;
    localparam int DIV_HI_LSB = DIV_DATA_W;
    localparam int DIV_HI_MSB = 2 * DIV_DATA_W - 1;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

endpackage : div_seq_pkg

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU, producing {remainder, quotient}.
// Operates on magnitudes; signs are latched at start and applied on the final iteration.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    div_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    // Dividend magnitude; quotient bits shift in from the bottom as it shifts out the top
    logic [DATA_W-1:0]     dvd_q, dvd_d;
    logic [DATA_W-1:0]     dvs_q, dvs_d;
    logic [DATA_W-1:0]     rem_q, rem_d;
    logic                  neg_quo_q, neg_quo_d;
    logic                  neg_rem_q, neg_rem_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q, ready_d;

    logic                  op1_neg, op2_neg;
    logic [DATA_W-1:0]     op1_mag, op2_mag;
    logic [DATA_W:0]       trial_shift, trial_diff;
    logic                  trial_ge;
    logic [DATA_W-1:0]     quo_next, rem_next;
    logic [DATA_W-1:0]     quo_fix, rem_fix;
    logic                  accept;

    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign op1_mag = op1_neg ? (DATA_W'(0) - opdata1_i) : opdata1_i;
    assign op2_mag = op2_neg ? (DATA_W'(0) - opdata2_i) : opdata2_i;
    assign accept  = start_i & ~annul_i;

    // Partial remainder stays below the divisor, so the shifted value is below 2*divisor
    // and fits in DATA_W+1 bits; the difference's top bit is therefore a clean borrow.
    assign trial_shift = {rem_q, dvd_q[DATA_W-1]};
    assign trial_diff  = trial_shift - {1'b0, dvs_q};
    assign trial_ge    = ~trial_diff[DATA_W];
    assign rem_next    = trial_ge ? trial_diff[DATA_W-1:0] : trial_shift[DATA_W-1:0];
    assign quo_next    = {dvd_q[DATA_W-2:0], trial_ge};

    assign quo_fix = neg_quo_q ? (DATA_W'(0) - quo_next) : quo_next;
    assign rem_fix = neg_rem_q ? (DATA_W'(0) - rem_next) : rem_next;

    always_comb begin
        // NOTE: every variable gets a hold value first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        unique case (state_q)
            DIV_IDLE: begin
                if (accept) begin
                    dvd_d     = op1_mag;
                    dvs_d     = op2_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = op1_neg ^ op2_neg;
                    neg_rem_d = op1_neg;
                    state_d   = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                end
            end

            DIV_BYZERO: begin
                if (annul_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    result_d = '0;
                    ready_d  = 1'b1;
                    state_d  = DIV_END;
                end
            end

            DIV_ON: begin
                if (annul_i) begin
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = DIV_IDLE;
                end else begin
                    dvd_d = quo_next;
                    rem_d = rem_next;
                    if (cnt_q == LAST_ITER) begin
                        cnt_d    = '0;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                        state_d  = DIV_END;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            DIV_END: begin
                if (annul_i || !start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    state_d  = DIV_IDLE;
                end
            end

            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule : div_seq

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus randomized DIV/DIVU
// traffic compared against plain-arithmetic reference results.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_asserts = 0;
    int n_fails   = 0;

    div_seq #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference: DIVU by plain unsigned arithmetic, DIV by 64-bit signed arithmetic
    // (truncating division, remainder carries the dividend's sign); divisor 0 gives 0.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue a request, hold start until ready, then drop it the same cycle ready is seen.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp_res, input bit toggle);
        int lat;
        int exp_lat;
        exp_lat      = (b == 32'd0) ? 1 : 32;
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!ready_o && lat < 40) begin
            if (toggle) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = $urandom_range(0, 1);
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, result_o, exp_res);
        start_i   = 1'b0;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        @(posedge clk); #1;
        check({tag, "_ready_drop"}, 64'(ready_o), 64'd0);
        check({tag, "_result_clear"}, result_o, 64'd0);
    endtask

    initial begin
        int cyc;
        logic [31:0] ra, rb;
        logic        rs;

        rst          = 1'b1;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_ready", 64'(ready_o), 64'd0);

        run_div("u_100_7",    32'd100,        32'd7,          1'b0, {32'd2, 32'd14}, 1'b0);
        run_div("s_m7_2",     32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_div("s_7_m2",     32'd7,          32'hFFFF_FFFE,  1'b1, {32'd1, 32'hFFFF_FFFD}, 1'b0);
        run_div("s_byzero",   32'h1234,       32'd0,          1'b1, 64'd0, 1'b0);
        run_div("u_byzero",   32'h1234,       32'd0,          1'b0, 64'd0, 1'b0);
        run_div("u_max_1",    32'hFFFF_FFFF,  32'd1,          1'b0, {32'd0, 32'hFFFF_FFFF}, 1'b0);
        run_div("s_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'd0, 32'h8000_0000}, 1'b0);
        run_div("u_ovf",      32'h8000_0000,  32'hFFFF_FFFF,  1'b0, {32'h8000_0000, 32'd0}, 1'b0);
        run_div("s_m8_m3",    32'hFFFF_FFF8,  32'hFFFF_FFFD,  1'b1, {32'hFFFF_FFFE, 32'd2}, 1'b0);

        // Annul sampled on the tenth edge of ON; ready must never rise
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        @(posedge clk); #1;
        repeat (9) begin
            @(posedge clk); #1;
        end
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        check("annul_ready_e10", 64'(ready_o), 64'd0);
        check("annul_result_e10", result_o, 64'd0);
        annul_i = 1'b0;
        @(posedge clk); #1;
        check("annul_ready_e11", 64'(ready_o), 64'd0);
        run_div("after_annul", 32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 1'b0);

        // Operand and sign changes during ON must not disturb the latched division
        run_div("toggle_u", 32'd123_456_789, 32'd1000, 1'b0, {32'd789, 32'd123_456}, 1'b1);
        run_div("toggle_s", 32'hFFFF_FF9C, 32'd7, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2}, 1'b1);

        // Async reset between edges in the middle of ON
        opdata1_i = 32'd12345;
        opdata2_i = 32'd67;
        start_i   = 1'b1;
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_on_ready", 64'(ready_o), 64'd0);
        check("rst_on_result", result_o, 64'd0);
        start_i = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Async reset while holding a finished result
        opdata1_i = 32'd99;
        opdata2_i = 32'd10;
        start_i   = 1'b1;
        cyc = 0;
        @(posedge clk); #1;
        while (!ready_o && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("end_reached_ready", 64'(ready_o), 64'd1);
        check("end_held_result", result_o, {32'd9, 32'd9});
        @(posedge clk); #1;
        check("end_hold_ready", 64'(ready_o), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_end_ready", 64'(ready_o), 64'd0);
        check("rst_end_result", result_o, 64'd0);
        start_i = 1'b0;
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic with occasional zero / small divisors and signed mixes
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom_range(0, 1));
            run_div($sformatf("rand%0d", i), ra, rb, rs, ref_div(ra, rb, rs), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule : tb_div_seq
